pwm_timebase: RTL and testbench

- Shared timebase and configuration controller for a bank of pwm_cell instances.
- Generates the free-running counter, counter ± period, and count direction.
- Double-buffers period/duty/phase/polarity so that new settings take effect only on a period boundary. This prevents glitched or runt PWM pulses.
- One instance drives any number of pwm_cell instances that share the same period.

---
 rtl/pwm_pkg.sv | 45 ++++
 rtl/pwm_shadow_reg.sv | 54 +++++
 rtl/pwm_timebase.sv | 149 ++++++++++++++
 tb/tb_pwm_timebase.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared types, reset configuration and helpers for the PWM timebase.
// Revision: 1.0 - initial release
// ============================================================================
package pwm_pkg;

   localparam int c_pwm_width = 32;

   typedef enum logic [1:0] {
      PWM_UP      = 2'd0,
      PWM_DOWN    = 2'd1,
      PWM_UP_DOWN = 2'd2
   } pwm_mode_e;

   typedef enum logic [1:0] {
      TB_IDLE     = 2'd0,
      TB_RUN_UP   = 2'd1,
      TB_RUN_DOWN = 2'd2
   } tb_state_e;

   typedef struct packed {
      pwm_mode_e              mode;
      logic                   polarity;
      logic [c_pwm_width-1:0] period;
      logic [c_pwm_width-1:0] duty;
      logic [c_pwm_width-1:0] phase;
   } pwm_cfg_t;

   localparam pwm_cfg_t c_cfg_reset = '{
      mode:     PWM_UP,
      polarity: 1'b0,
      period:   '0,
      duty:     '0,
      phase:    '0
   };

   // Highest counter value of a period; periods 0 and 1 collapse to a held 0.
   function automatic logic [c_pwm_width-1:0] pwm_top(input logic [c_pwm_width-1:0] period);
      return (period < c_pwm_width'(2)) ? '0 : period - c_pwm_width'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_shadow_reg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_shadow_reg
// Brief   : Valid/ready shadow register feeding the active PWM configuration.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_shadow_reg
   import pwm_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     i_cfg_valid,
   output logic     o_cfg_ready,
   input  pwm_cfg_t i_cfg,
   input  logic     i_apply_req,
   output pwm_cfg_t o_active,
   output pwm_cfg_t o_next
);

   pwm_cfg_t r_shadow;
   pwm_cfg_t r_active;
   logic     r_full;
   logic     r_clr;
   logic     w_apply;

   // r_clr holds the shadow full for one cycle after a transfer so cfg_ready
   // rises one cycle after the new settings become visible.
   assign w_apply     = i_apply_req && r_full && !r_clr;
   assign o_cfg_ready = !r_full;
   assign o_active    = r_active;
   assign o_next      = w_apply ? r_shadow : r_active;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow <= c_cfg_reset;
         r_active <= c_cfg_reset;
         r_full   <= 1'b0;
         r_clr    <= 1'b0;
      end else begin
         r_clr <= w_apply;
         if (w_apply) begin
            r_active <= r_shadow;
         end
         if (r_clr) begin
            r_full <= 1'b0;
         end else if (i_cfg_valid && !r_full) begin
            r_full   <= 1'b1;
            r_shadow <= i_cfg;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module  : pwm_timebase
// Brief   : Shared PWM counter/FSM with period-boundary configuration update.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int COUNTER_WIDTH = c_pwm_width
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     sync_in,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [1:0]               cfg_mode,
   input  logic                     cfg_polarity,
   input  logic [COUNTER_WIDTH-1:0] cfg_period,
   input  logic [COUNTER_WIDTH-1:0] cfg_duty,
   input  logic [COUNTER_WIDTH-1:0] cfg_phase,
   output logic [COUNTER_WIDTH-1:0] counter,
   output logic [COUNTER_WIDTH-1:0] counter_plus_period,
   output logic [COUNTER_WIDTH-1:0] counter_minus_period,
   output logic                     count_dir,
   output logic                     polarity,
   output logic [COUNTER_WIDTH-1:0] period,
   output logic [COUNTER_WIDTH-1:0] duty,
   output logic [COUNTER_WIDTH-1:0] phase,
   output logic                     period_end
);

   tb_state_e                r_state;
   logic [COUNTER_WIDTH-1:0] r_counter;
   logic                     r_dir;
   logic                     r_pe;

   pwm_mode_e                w_mode_in;
   pwm_cfg_t                 w_cfg_in;
   pwm_cfg_t                 w_act;
   pwm_cfg_t                 w_nxt;
   logic                     w_run;
   logic                     w_degen;
   logic                     w_up_bnd;
   logic                     w_dn_bnd;
   logic                     w_ud_turn;
   logic                     w_restart;
   logic                     w_apply_req;
   logic                     w_bounce;
   tb_state_e                w_rs_state;
   logic [COUNTER_WIDTH-1:0] w_rs_count;
   logic                     w_rs_dir;

   assign w_mode_in = (cfg_mode == 2'd3) ? PWM_UP : pwm_mode_e'(cfg_mode);
   assign w_cfg_in  = '{mode: w_mode_in, polarity: cfg_polarity, period: cfg_period,
                        duty: cfg_duty, phase: cfg_phase};

   pwm_shadow_reg u_shadow (
      .clk         (clk),
      .rst         (rst),
      .i_cfg_valid (cfg_valid),
      .o_cfg_ready (cfg_ready),
      .i_cfg       (w_cfg_in),
      .i_apply_req (w_apply_req),
      .o_active    (w_act),
      .o_next      (w_nxt)
   );

   // Boundaries use the active period; >= lets an out-of-range count self-correct.
   assign w_run     = (r_state != TB_IDLE);
   assign w_degen   = (w_act.period < COUNTER_WIDTH'(2));
   assign w_up_bnd  = w_degen || (r_counter >= pwm_top(w_act.period));
   assign w_dn_bnd  = (r_counter == '0);
   assign w_ud_turn = (w_act.mode == PWM_UP_DOWN) && !w_degen;
   assign w_restart = w_run && enable &&
                      (sync_in ||
                       ((r_state == TB_RUN_UP) && w_up_bnd && !w_ud_turn) ||
                       ((r_state == TB_RUN_DOWN) && w_dn_bnd));
   assign w_apply_req = (r_state == TB_IDLE) || w_restart;
   assign w_bounce  = (r_state == TB_RUN_DOWN) && !sync_in &&
                      (w_act.mode == PWM_UP_DOWN) && (w_nxt.mode == PWM_UP_DOWN) &&
                      (w_nxt.period >= COUNTER_WIDTH'(2));

   // Restart target is taken from the configuration that is active after this edge.
   always_comb begin
      w_rs_state = TB_RUN_UP;
      w_rs_count = '0;
      w_rs_dir   = 1'b1;
      if (w_nxt.mode == PWM_DOWN) begin
         w_rs_state = TB_RUN_DOWN;
         w_rs_count = pwm_top(w_nxt.period);
         w_rs_dir   = 1'b0;
      end else if (w_bounce) begin
         w_rs_count = COUNTER_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         r_state   <= TB_IDLE;
         r_counter <= '0;
         r_dir     <= 1'b1;
         r_pe      <= 1'b0;
      end else begin
         r_pe <= 1'b0;
         case (r_state)
            TB_IDLE: begin
               r_state   <= w_rs_state;
               r_counter <= w_rs_count;
               r_dir     <= w_rs_dir;
            end
            TB_RUN_UP, TB_RUN_DOWN: begin
               if (w_restart) begin
                  r_state   <= w_rs_state;
                  r_counter <= w_rs_count;
                  r_dir     <= w_rs_dir;
                  r_pe      <= 1'b1;
               end else if ((r_state == TB_RUN_UP) && w_up_bnd) begin
                  r_state   <= TB_RUN_DOWN;
                  r_counter <= w_act.period - COUNTER_WIDTH'(2);
                  r_dir     <= 1'b0;
               end else if (r_state == TB_RUN_UP) begin
                  r_counter <= r_counter + COUNTER_WIDTH'(1);
               end else begin
                  r_counter <= r_counter - COUNTER_WIDTH'(1);
               end
            end
            default: begin
               r_state   <= TB_IDLE;
               r_counter <= '0;
               r_dir     <= 1'b1;
            end
         endcase
      end
   end

   assign counter              = r_counter;
   assign counter_plus_period  = r_counter + w_act.period;
   assign counter_minus_period = r_counter - w_act.period;
   assign count_dir            = r_dir;
   assign period_end           = r_pe;
   assign polarity             = w_act.polarity;
   assign period               = w_act.period;
   assign duty                 = w_act.duty;
   assign phase                = w_act.phase;

endmodule
`default_nettype wire

// File: tb/tb_pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_timebase
// Brief   : Directed self-checking bench for pwm_timebase.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pwm_timebase;

   localparam logic [1:0] c_up   = 2'd0;
   localparam logic [1:0] c_down = 2'd1;
   localparam logic [1:0] c_ud   = 2'd2;
   localparam logic [1:0] c_rsv  = 2'd3;

   logic        clk = 1'b0;
   logic        rst, enable, sync_in, cfg_valid, cfg_ready, cfg_polarity;
   logic [1:0]  cfg_mode;
   logic [31:0] cfg_period, cfg_duty, cfg_phase;
   logic [31:0] counter, counter_plus_period, counter_minus_period;
   logic        count_dir, polarity, period_end;
   logic [31:0] period, duty, phase;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        en;
      logic        sync;
      logic [31:0] cnt;
      logic        dir;
      logic        pe;
   } vec_t;

   vec_t ud_vec[20];

   pwm_timebase #(.COUNTER_WIDTH(32)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .enable               (enable),
      .sync_in              (sync_in),
      .cfg_valid            (cfg_valid),
      .cfg_ready            (cfg_ready),
      .cfg_mode             (cfg_mode),
      .cfg_polarity         (cfg_polarity),
      .cfg_period           (cfg_period),
      .cfg_duty             (cfg_duty),
      .cfg_phase            (cfg_phase),
      .counter              (counter),
      .counter_plus_period  (counter_plus_period),
      .counter_minus_period (counter_minus_period),
      .count_dir            (count_dir),
      .polarity             (polarity),
      .period               (period),
      .duty                 (duty),
      .phase                (phase),
      .period_end           (period_end)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_cfg(input logic [1:0] m, input logic pol,
                           input logic [31:0] per, input logic [31:0] dty, input logic [31:0] ph);
      chk("cfg_ready_before_write", {31'd0, cfg_ready}, 32'd1);
      cfg_mode     = m;
      cfg_polarity = pol;
      cfg_period   = per;
      cfg_duty     = dty;
      cfg_phase    = ph;
      cfg_valid    = 1'b1;
      step();
      cfg_valid    = 1'b0;
   endtask

   task automatic wait_counter(input logic [31:0] target, input int budget);
      for (int i = 0; i < budget && counter !== target; i++) step();
      chk("wait_counter", counter, target);
   endtask

   initial begin
      int npe;
      ud_vec[0]  = '{1'b1, 1'b0, 32'd1, 1'b1, 1'b0};
      ud_vec[1]  = '{1'b1, 1'b0, 32'd2, 1'b1, 1'b0};
      ud_vec[2]  = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b0};
      ud_vec[3]  = '{1'b1, 1'b0, 32'd2, 1'b0, 1'b0};
      ud_vec[4]  = '{1'b1, 1'b0, 32'd1, 1'b0, 1'b0};
      ud_vec[5]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0};
      ud_vec[6]  = '{1'b1, 1'b0, 32'd1, 1'b1, 1'b1};
      ud_vec[7]  = '{1'b1, 1'b0, 32'd2, 1'b1, 1'b0};
      ud_vec[8]  = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b0};
      ud_vec[9]  = '{1'b1, 1'b0, 32'd2, 1'b0, 1'b0};
      ud_vec[10] = '{1'b1, 1'b0, 32'd1, 1'b0, 1'b0};
      ud_vec[11] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0};
      ud_vec[12] = '{1'b1, 1'b0, 32'd1, 1'b1, 1'b1};
      ud_vec[13] = '{1'b1, 1'b0, 32'd2, 1'b1, 1'b0};
      ud_vec[14] = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b0};
      ud_vec[15] = '{1'b1, 1'b0, 32'd2, 1'b0, 1'b0};
      ud_vec[16] = '{1'b1, 1'b1, 32'd0, 1'b1, 1'b1};
      ud_vec[17] = '{1'b1, 1'b0, 32'd1, 1'b1, 1'b0};
      ud_vec[18] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0};
      ud_vec[19] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0};

      rst = 1'b1; enable = 1'b0; sync_in = 1'b0; cfg_valid = 1'b0;
      cfg_mode = c_up; cfg_polarity = 1'b0;
      cfg_period = '0; cfg_duty = '0; cfg_phase = '0;
      step(); step();
      rst = 1'b0;

      // Reset state
      chk("rst_counter", counter, 32'd0);
      chk("rst_dir", {31'd0, count_dir}, 32'd1);
      chk("rst_pe", {31'd0, period_end}, 32'd0);
      chk("rst_period", period, 32'd0);
      chk("rst_polarity", {31'd0, polarity}, 32'd0);
      chk("rst_ready", {31'd0, cfg_ready}, 32'd1);

      // UP, period 1000, applied in IDLE
      send_cfg(c_up, 1'b1, 32'd1000, 32'd500, 32'd0);
      chk("cap_ready_low", {31'd0, cfg_ready}, 32'd0);
      step();
      chk("idle_apply_period", period, 32'd1000);
      chk("idle_apply_duty", duty, 32'd500);
      chk("idle_apply_pol", {31'd0, polarity}, 32'd1);
      chk("idle_apply_ready_still_low", {31'd0, cfg_ready}, 32'd0);
      step();
      chk("idle_ready_back", {31'd0, cfg_ready}, 32'd1);
      enable = 1'b1;
      step();
      chk("up_start_cnt", counter, 32'd0);
      chk("up_start_pe", {31'd0, period_end}, 32'd0);
      repeat (999) step();
      chk("up_top_cnt", counter, 32'd999);
      chk("up_top_plus", counter_plus_period, 32'd1999);
      chk("up_top_minus", counter_minus_period, 32'hFFFF_FFFF);
      chk("up_top_pe", {31'd0, period_end}, 32'd0);
      step();
      chk("up_wrap_cnt", counter, 32'd0);
      chk("up_wrap_pe", {31'd0, period_end}, 32'd1);
      chk("up_wrap_minus", counter_minus_period, 32'hFFFF_FC18);
      npe = 0;
      repeat (1000) begin
         step();
         npe += int'(period_end);
      end
      chk("up_pe_per_1000", npe, 32'd1);
      chk("up_after_1000_cnt", counter, 32'd0);

      // Mid-period reconfiguration waits for the wrap
      wait_counter(32'd300, 1000);
      send_cfg(c_up, 1'b1, 32'd750, 32'd500, 32'd0);
      chk("mid_ready_low", {31'd0, cfg_ready}, 32'd0);
      chk("mid_period_kept", period, 32'd1000);
      for (int i = 0; i < 1000 && period_end !== 1'b1; i++) step();
      chk("mid_wrap_pe", {31'd0, period_end}, 32'd1);
      chk("mid_wrap_cnt", counter, 32'd0);
      chk("mid_wrap_period", period, 32'd750);
      chk("mid_wrap_ready", {31'd0, cfg_ready}, 32'd0);
      step();
      chk("mid_post_ready", {31'd0, cfg_ready}, 32'd1);
      chk("mid_post_cnt", counter, 32'd1);
      repeat (748) step();
      chk("p750_top", counter, 32'd749);
      step();
      chk("p750_wrap_cnt", counter, 32'd0);
      chk("p750_wrap_pe", {31'd0, period_end}, 32'd1);
      enable = 1'b0;
      step();
      chk("disable_cnt", counter, 32'd0);
      chk("disable_pe", {31'd0, period_end}, 32'd0);

      // UP_DOWN period 4, table-driven
      send_cfg(c_ud, 1'b0, 32'd4, 32'd2, 32'd0);
      step(); step();
      chk("ud_period", period, 32'd4);
      enable = 1'b1;
      step();
      chk("ud_start_cnt", counter, 32'd0);
      for (int i = 0; i < 20; i++) begin
         enable  = ud_vec[i].en;
         sync_in = ud_vec[i].sync;
         step();
         chk($sformatf("ud_cnt[%0d]", i), counter, ud_vec[i].cnt);
         chk($sformatf("ud_dir[%0d]", i), {31'd0, count_dir}, {31'd0, ud_vec[i].dir});
         chk($sformatf("ud_pe[%0d]", i), {31'd0, period_end}, {31'd0, ud_vec[i].pe});
      end
      sync_in = 1'b0;

      // DOWN period 2000, sync applies a pending phase
      send_cfg(c_down, 1'b0, 32'd2000, 32'd1000, 32'd0);
      step(); step();
      enable = 1'b1;
      step();
      chk("dn_start_cnt", counter, 32'd1999);
      chk("dn_start_dir", {31'd0, count_dir}, 32'd0);
      chk("dn_start_pe", {31'd0, period_end}, 32'd0);
      wait_counter(32'd1201, 1000);
      send_cfg(c_down, 1'b0, 32'd2000, 32'd1000, 32'hFFFF_FC18);
      chk("dn_pending_cnt", counter, 32'd1200);
      chk("dn_pending_phase_old", phase, 32'd0);
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      chk("dn_sync_cnt", counter, 32'd1999);
      chk("dn_sync_pe", {31'd0, period_end}, 32'd1);
      chk("dn_sync_phase", phase, 32'hFFFF_FC18);
      chk("dn_sync_ready", {31'd0, cfg_ready}, 32'd0);
      step();
      chk("dn_post_cnt", counter, 32'd1998);
      chk("dn_post_pe", {31'd0, period_end}, 32'd0);
      chk("dn_post_ready", {31'd0, cfg_ready}, 32'd1);

      // Degenerate periods 1 and 0 (0 via reserved mode, treated as UP)
      send_cfg(c_up, 1'b0, 32'd1, 32'd0, 32'd0);
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      chk("p1_cnt", counter, 32'd0);
      chk("p1_pe", {31'd0, period_end}, 32'd1);
      chk("p1_period", period, 32'd1);
      chk("p1_dir", {31'd0, count_dir}, 32'd1);
      step();
      chk("p1_hold_cnt", counter, 32'd0);
      chk("p1_hold_pe", {31'd0, period_end}, 32'd1);
      send_cfg(c_rsv, 1'b0, 32'd0, 32'd0, 32'd0);
      step();
      chk("p0_period", period, 32'd0);
      chk("p0_cnt", counter, 32'd0);
      chk("p0_pe", {31'd0, period_end}, 32'd1);
      step();
      chk("p0_hold_pe", {31'd0, period_end}, 32'd1);
      enable = 1'b0;
      step();
      chk("p0_idle_pe", {31'd0, period_end}, 32'd0);
      chk("p0_idle_cnt", counter, 32'd0);

      // Reset mid down-count with a pending shadow
      send_cfg(c_ud, 1'b1, 32'd10, 32'd3, 32'd7);
      step(); step();
      enable = 1'b1;
      step();
      for (int i = 0; i < 30 && count_dir !== 1'b0; i++) step();
      chk("rr_down_cnt", counter, 32'd8);
      step();
      send_cfg(c_ud, 1'b0, 32'd77, 32'd0, 32'd0);
      chk("rr_pending_ready", {31'd0, cfg_ready}, 32'd0);
      chk("rr_pending_cnt", counter, 32'd6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rr_cnt", counter, 32'd0);
      chk("rr_dir", {31'd0, count_dir}, 32'd1);
      chk("rr_pe", {31'd0, period_end}, 32'd0);
      chk("rr_period", period, 32'd0);
      chk("rr_duty", duty, 32'd0);
      chk("rr_polarity", {31'd0, polarity}, 32'd0);
      chk("rr_ready", {31'd0, cfg_ready}, 32'd1);
      step(); step(); step();
      chk("rr_no_apply_period", period, 32'd0);
      chk("rr_degen_cnt", counter, 32'd0);
      chk("rr_degen_pe", {31'd0, period_end}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
